// File: rtl/rpn_wan_tx.sv
// rpn_wan_tx: reliable WAN publish transmitter.
// Stamps each single-beat publish with the next per-cluster sequence number,
// sends it over KnownIP, retransmits on timeout, falls back to a sequence
// number check, and records the sequence number only on confirmed delivery.
`timescale 1ns/1ps
module rpn_wan_tx #(
  parameter int AXIS_DATA_WIDTH           = 512,
  parameter int AXIS_KEEP_WIDTH           = 64,
  parameter int AXIS_KIP_TUSER_WIDTH      = 64,
  parameter int CLUSTER_ID_WIDTH          = 32,
  parameter int IP_ADDRESS_WIDTH          = 32,
  parameter int IP_PORT_WIDTH             = 16,
  parameter int BRAM_ADDR_WIDTH           = 32,
  parameter int BRAM_WEN_WIDTH            = 4,
  parameter int WAN_SEQUENCE_NUMBER_WIDTH = 32,
  parameter int RPN_MSG_TYPE_WIDTH        = 8,
  // control API header layout (publish frame and ACK/REPLY share it)
  parameter int PUB_WAN_TYPE_OFFSET       = 0,
  parameter int PUB_WAN_CTID_OFFSET       = 8,
  parameter int PUB_WAN_SEQ_OFFSET        = 40,
  parameter int PUB_WAN_DATA_OFFSET       = 72,
  parameter int PUB_WAN_DATA_WIDTH        = 440,
  parameter int WAN_ACK_TYPE_OFFSET       = 0,
  parameter int WAN_ACK_CTID_OFFSET       = 8,
  parameter int WAN_ACK_SEQ_OFFSET        = 40,
  parameter int KIP_TUSER_IP_OFFSET       = 0,
  parameter int KIP_TUSER_SRC_PORT_OFFSET = 32,
  parameter int KIP_TUSER_DST_PORT_OFFSET = 48,
  parameter int RPN_MSG_TYPE_WAN_PUB            = 1,
  parameter int RPN_MSG_TYPE_WAN_ACK            = 2,
  parameter int RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK  = 3,
  parameter int RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY  = 4,
  parameter int TIMEOUT_CYCLES            = 1000,
  parameter int MAX_RETRIES               = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_ap_rst,
  input  logic [CLUSTER_ID_WIDTH-1:0]          i_cluster_id,
  input  logic [IP_PORT_WIDTH-1:0]             i_KIP_port_number,
  input  logic                                 from_ctrl_tvalid,
  output logic                                 from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           from_ctrl_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]           from_ctrl_tkeep,
  input  logic                                 from_ctrl_tlast,
  input  logic [CLUSTER_ID_WIDTH-1:0]          from_ctrl_tdest,
  input  logic [IP_ADDRESS_WIDTH-1:0]          from_ctrl_tuser,
  output logic                                 to_nb_KIP_tvalid,
  input  logic                                 to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           to_nb_KIP_tkeep,
  output logic [AXIS_KIP_TUSER_WIDTH-1:0]      to_nb_KIP_tuser,
  output logic                                 to_nb_KIP_tlast,
  input  logic                                 from_nb_ack_tvalid,
  output logic                                 from_nb_ack_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           from_nb_ack_tdata,
  output logic                                 to_sequence_number_BRAM_CLK,
  output logic                                 to_sequence_number_BRAM_RST,
  output logic                                 to_sequence_number_BRAM_EN,
  output logic [BRAM_WEN_WIDTH-1:0]            to_sequence_number_BRAM_WEN,
  output logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] to_sequence_number_BRAM_DIN,
  output logic [BRAM_ADDR_WIDTH-1:0]           to_sequence_number_BRAM_ADDR,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] to_sequence_number_BRAM_DOUT,
  output logic                                 o_tx_done,
  output logic                                 o_tx_error
);

  localparam int SW = WAN_SEQUENCE_NUMBER_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] TYPE_PUB   = RPN_MSG_TYPE_WIDTH'(RPN_MSG_TYPE_WAN_PUB);
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] TYPE_ACK   = RPN_MSG_TYPE_WIDTH'(RPN_MSG_TYPE_WAN_ACK);
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] TYPE_CHECK = RPN_MSG_TYPE_WIDTH'(RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK);
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] TYPE_REPLY = RPN_MSG_TYPE_WIDTH'(RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_SEQ   = 3'd1,
    ST_SEND_MSG   = 3'd2,
    ST_WAIT_ACK   = 3'd3,
    ST_SEND_CHECK = 3'd4,
    ST_WAIT_REPLY = 3'd5,
    ST_WRITE_SEQ  = 3'd6
  } state_t;

  state_t                              state_r;
  logic [PUB_WAN_DATA_WIDTH-1:0]       payload_r;
  logic [CLUSTER_ID_WIDTH-1:0]         tdest_r;
  logic [IP_ADDRESS_WIDTH-1:0]         ip_r;
  logic [BRAM_ADDR_WIDTH-1:0]          addr_r;
  logic [SW-1:0]                       seq_r;
  logic [TW-1:0]                       timer_r;
  logic [RW-1:0]                       retries_r;
  logic                                kip_tvalid_r;
  logic [AXIS_DATA_WIDTH-1:0]          kip_tdata_r;
  logic [AXIS_KIP_TUSER_WIDTH-1:0]     kip_tuser_r;
  logic                                ctrl_tready_r;
  logic                                ack_tready_r;
  logic                                wr_en_r;
  logic [BRAM_WEN_WIDTH-1:0]           wen_r;
  logic                                done_r;
  logic                                error_r;

  // Assemble an outgoing frame; every bit not covered by a field stays zero.
  function automatic logic [AXIS_DATA_WIDTH-1:0] build_frame(
    input logic [RPN_MSG_TYPE_WIDTH-1:0] msg_type,
    input logic [CLUSTER_ID_WIDTH-1:0]   ctid,
    input logic [SW-1:0]                 seq,
    input logic [PUB_WAN_DATA_WIDTH-1:0] payload
  );
    logic [AXIS_DATA_WIDTH-1:0] f;
    f = {AXIS_DATA_WIDTH{1'b0}};
    f[PUB_WAN_TYPE_OFFSET +: RPN_MSG_TYPE_WIDTH] = msg_type;
    f[PUB_WAN_CTID_OFFSET +: CLUSTER_ID_WIDTH]   = ctid;
    f[PUB_WAN_SEQ_OFFSET  +: SW]                 = seq;
    f[PUB_WAN_DATA_OFFSET +: PUB_WAN_DATA_WIDTH] = payload;
    return f;
  endfunction

  // KnownIP sideband: destination IP, same UDP port used as source and destination.
  function automatic logic [AXIS_KIP_TUSER_WIDTH-1:0] build_tuser(
    input logic [IP_ADDRESS_WIDTH-1:0] ip,
    input logic [IP_PORT_WIDTH-1:0]    port
  );
    logic [AXIS_KIP_TUSER_WIDTH-1:0] u;
    u = {AXIS_KIP_TUSER_WIDTH{1'b0}};
    u[KIP_TUSER_IP_OFFSET       +: IP_ADDRESS_WIDTH] = ip;
    u[KIP_TUSER_SRC_PORT_OFFSET +: IP_PORT_WIDTH]    = port;
    u[KIP_TUSER_DST_PORT_OFFSET +: IP_PORT_WIDTH]    = port;
    return u;
  endfunction

  logic                          accept_s;
  logic [BRAM_ADDR_WIDTH-1:0]    rd_addr_s;
  logic [SW-1:0]                 next_seq_s;
  logic                          beat_s;
  logic                          ctid_ok_s;
  logic                          ack_hit_s;
  logic                          reply_s;
  logic                          seq_hit_s;
  logic                          timeout_s;
  logic                          unused_s;

  assign accept_s   = (state_r == ST_IDLE) && ctrl_tready_r && from_ctrl_tvalid;
  assign rd_addr_s  = {from_ctrl_tdest[BRAM_ADDR_WIDTH-3:0], 2'b00};
  assign next_seq_s = to_sequence_number_BRAM_DOUT + SW'(1);
  assign beat_s     = from_nb_ack_tvalid && ack_tready_r;
  assign ctid_ok_s  = beat_s && (from_nb_ack_tdata[WAN_ACK_CTID_OFFSET +: CLUSTER_ID_WIDTH] == tdest_r);
  assign seq_hit_s  = (from_nb_ack_tdata[WAN_ACK_SEQ_OFFSET +: SW] == seq_r);
  assign ack_hit_s  = ctid_ok_s && seq_hit_s &&
                      (from_nb_ack_tdata[WAN_ACK_TYPE_OFFSET +: RPN_MSG_TYPE_WIDTH] == TYPE_ACK);
  assign reply_s    = ctid_ok_s &&
                      (from_nb_ack_tdata[WAN_ACK_TYPE_OFFSET +: RPN_MSG_TYPE_WIDTH] == TYPE_REPLY);
  assign timeout_s  = (timer_r == TIMER_LAST);
  assign unused_s   = ^{from_ctrl_tkeep, from_ctrl_tlast, from_ctrl_tdata, from_ctrl_tdest, from_nb_ack_tdata};

  // The read must reach the BRAM in the acceptance cycle so DOUT is ready in LOAD_SEQ.
  assign to_sequence_number_BRAM_CLK  = i_clk;
  assign to_sequence_number_BRAM_RST  = i_ap_rst;
  assign to_sequence_number_BRAM_EN   = accept_s | wr_en_r;
  assign to_sequence_number_BRAM_WEN  = wen_r;
  assign to_sequence_number_BRAM_DIN  = seq_r;
  assign to_sequence_number_BRAM_ADDR = accept_s ? rd_addr_s : addr_r;

  assign from_ctrl_tready   = ctrl_tready_r;
  assign from_nb_ack_tready = ack_tready_r;
  assign to_nb_KIP_tvalid   = kip_tvalid_r;
  assign to_nb_KIP_tdata    = kip_tdata_r;
  assign to_nb_KIP_tuser    = kip_tuser_r;
  assign to_nb_KIP_tkeep    = {AXIS_KEEP_WIDTH{kip_tvalid_r}};
  assign to_nb_KIP_tlast    = kip_tvalid_r;
  assign o_tx_done          = done_r;
  assign o_tx_error         = error_r;

  // Transmit/retry state machine with all control outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state_r       <= ST_IDLE;
      payload_r     <= {PUB_WAN_DATA_WIDTH{1'b0}};
      tdest_r       <= {CLUSTER_ID_WIDTH{1'b0}};
      ip_r          <= {IP_ADDRESS_WIDTH{1'b0}};
      addr_r        <= {BRAM_ADDR_WIDTH{1'b0}};
      seq_r         <= {SW{1'b0}};
      timer_r       <= {TW{1'b0}};
      retries_r     <= {RW{1'b0}};
      kip_tvalid_r  <= 1'b0;
      kip_tdata_r   <= {AXIS_DATA_WIDTH{1'b0}};
      kip_tuser_r   <= {AXIS_KIP_TUSER_WIDTH{1'b0}};
      ctrl_tready_r <= 1'b0;
      ack_tready_r  <= 1'b0;
      wr_en_r       <= 1'b0;
      wen_r         <= {BRAM_WEN_WIDTH{1'b0}};
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      ack_tready_r <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      wen_r        <= {BRAM_WEN_WIDTH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            payload_r     <= from_ctrl_tdata[PUB_WAN_DATA_WIDTH-1:0];
            tdest_r       <= from_ctrl_tdest;
            ip_r          <= from_ctrl_tuser;
            addr_r        <= rd_addr_s;
            ctrl_tready_r <= 1'b0;
            state_r       <= ST_LOAD_SEQ;
          end else begin
            ctrl_tready_r <= 1'b1;
          end
        end
        ST_LOAD_SEQ: begin
          seq_r        <= next_seq_s;
          retries_r    <= {RW{1'b0}};
          kip_tdata_r  <= build_frame(TYPE_PUB, i_cluster_id, next_seq_s, payload_r);
          kip_tuser_r  <= build_tuser(ip_r, i_KIP_port_number);
          kip_tvalid_r <= 1'b1;
          state_r      <= ST_SEND_MSG;
        end
        ST_SEND_MSG, ST_SEND_CHECK: begin
          if (to_nb_KIP_tready) begin
            kip_tvalid_r <= 1'b0;
            timer_r      <= {TW{1'b0}};
            state_r      <= (state_r == ST_SEND_MSG) ? ST_WAIT_ACK : ST_WAIT_REPLY;
          end else begin
            kip_tvalid_r <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_hit_s) begin
            wr_en_r <= 1'b1;
            wen_r   <= {BRAM_WEN_WIDTH{1'b1}};
            done_r  <= 1'b1;
            state_r <= ST_WRITE_SEQ;
          end else if (timeout_s && (retries_r < RETRY_LIMIT)) begin
            retries_r    <= retries_r + RW'(1);
            kip_tvalid_r <= 1'b1;
            state_r      <= ST_SEND_MSG;
          end else if (timeout_s) begin
            kip_tdata_r  <= build_frame(TYPE_CHECK, i_cluster_id, seq_r, {PUB_WAN_DATA_WIDTH{1'b0}});
            kip_tvalid_r <= 1'b1;
            state_r      <= ST_SEND_CHECK;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_WAIT_REPLY: begin
          if (reply_s && seq_hit_s) begin
            wr_en_r <= 1'b1;
            wen_r   <= {BRAM_WEN_WIDTH{1'b1}};
            done_r  <= 1'b1;
            state_r <= ST_WRITE_SEQ;
          end else if (reply_s || timeout_s) begin
            error_r       <= 1'b1;
            ctrl_tready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_WRITE_SEQ: begin
          ctrl_tready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
        default: begin
          ctrl_tready_r <= 1'b0;
          kip_tvalid_r  <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
